spi_master_rw: RTL and testbench

//  Parametrised SPI master for the LCD/HDP control port: one frame = R/W bit + address + data, MSB first.

---
 rtl/spi_master_rw.sv | 140 ++++++++++++++
 tb/tb_spi_master_rw.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_rw.sv
// Parametrised SPI master for the LCD/HDP control port.
// One frame = R/W bit + address + data, MSB first, with optional read-back on i_sdi.
module spi_master_rw #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 1,
    parameter int CS_SETUP   = 1,
    parameter int CS_HOLD    = 1,
    parameter int CS_GAP     = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_txBegin,
    input  logic                  i_txRead,
    input  logic [ADDR_WIDTH-1:0] i_txAddress,
    input  logic [DATA_WIDTH-1:0] i_txData,
    output logic                  o_txBusy,
    output logic                  o_txDone,
    output logic [DATA_WIDTH-1:0] o_rxData,
    output logic                  o_sen,
    output logic                  o_sck,
    output logic                  o_sdat,
    input  logic                  i_sdi
);

    localparam int NBITS = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int BW    = $clog2(NBITS + 1);
    localparam int DW    = $clog2(CLK_DIV + 1);
    localparam int MAXHG = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAXC  = (CS_SETUP > MAXHG) ? CS_SETUP : MAXHG;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state;
    logic [NBITS-1:0]      txShift;
    logic [DATA_WIDTH-1:0] rxShift;
    logic                  isRead;
    logic                  phase;
    logic [BW-1:0]         bitIdx;
    logic [DW-1:0]         divCnt;
    logic [CW-1:0]         cnt;
    logic                  inData;
    logic                  nextInData;

    assign inData     = bitIdx >= BW'(1 + ADDR_WIDTH);
    assign nextInData = bitIdx >= BW'(ADDR_WIDTH);

    always_ff @(posedge i_clock) begin
        o_txDone <= 1'b0;
        if (i_reset) begin
            state    <= IDLE;
            txShift  <= '0;
            rxShift  <= '0;
            isRead   <= 1'b0;
            phase    <= 1'b0;
            bitIdx   <= '0;
            divCnt   <= '0;
            cnt      <= '0;
            o_txBusy <= 1'b0;
            o_rxData <= '0;
            o_sen    <= 1'b1;
            o_sck    <= 1'b0;
            o_sdat   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_txBegin) begin
                        state    <= SETUP;
                        txShift  <= {i_txRead, i_txAddress, i_txData};
                        rxShift  <= '0;
                        isRead   <= i_txRead;
                        cnt      <= CW'(CS_SETUP - 1);
                        o_txBusy <= 1'b1;
                        o_sen    <= 1'b0;
                        o_sdat   <= i_txRead;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state  <= SHIFT;
                        phase  <= 1'b0;
                        bitIdx <= '0;
                        divCnt <= DW'(CLK_DIV - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (divCnt != '0) begin
                        divCnt <= divCnt - 1'b1;
                    end else if (!phase) begin
                        phase  <= 1'b1;
                        o_sck  <= 1'b1;
                        divCnt <= DW'(CLK_DIV - 1);
                        if (isRead && inData)
                            rxShift <= (rxShift << 1) | DATA_WIDTH'(i_sdi);
                    end else begin
                        o_sck <= 1'b0;
                        if (bitIdx == BW'(NBITS - 1)) begin
                            state  <= HOLD;
                            o_sdat <= 1'b0;
                            cnt    <= CW'(CS_HOLD - 1);
                        end else begin
                            // read frames keep MOSI low while the slave returns data
                            phase   <= 1'b0;
                            bitIdx  <= bitIdx + 1'b1;
                            divCnt  <= DW'(CLK_DIV - 1);
                            txShift <= txShift << 1;
                            o_sdat  <= (isRead && nextInData) ? 1'b0
                                                              : txShift[NBITS-2];
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state    <= GAP;
                        o_sen    <= 1'b1;
                        o_txDone <= 1'b1;
                        cnt      <= CW'(CS_GAP - 1);
                        if (isRead)
                            o_rxData <= rxShift;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        o_txBusy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_rw.sv
// Scoreboard bench for spi_master_rw: default-parameter instance
// plus a wide/slow instance (CLK_DIV=4, 15/16-bit frame, CS_GAP=3).
module tb_spi_master_rw;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txBegin = 1'b0;
    logic       txRead = 1'b0;
    logic [6:0] txAddr = '0;
    logic [7:0] txData = '0;
    logic       sdi = 1'b0;
    logic       o_txBusy, o_txDone, o_sen, o_sck, o_sdat;
    logic [7:0] o_rxData;

    logic        txBegin6 = 1'b0;
    logic [14:0] txAddr6 = '0;
    logic [15:0] txData6 = '0;
    logic        o_txBusy6, o_txDone6, o_sen6, o_sck6, o_sdat6;
    logic [15:0] o_rxData6;

    always #5 clk = ~clk;

    spi_master_rw dut (
        .i_clock(clk), .i_reset(rst), .i_txBegin(txBegin),
        .i_txRead(txRead), .i_txAddress(txAddr), .i_txData(txData),
        .o_txBusy(o_txBusy), .o_txDone(o_txDone), .o_rxData(o_rxData),
        .o_sen(o_sen), .o_sck(o_sck), .o_sdat(o_sdat), .i_sdi(sdi)
    );

    spi_master_rw #(
        .ADDR_WIDTH(15), .DATA_WIDTH(16), .CLK_DIV(4),
        .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(3)
    ) dut6 (
        .i_clock(clk), .i_reset(rst), .i_txBegin(txBegin6),
        .i_txRead(1'b0), .i_txAddress(txAddr6), .i_txData(txData6),
        .o_txBusy(o_txBusy6), .o_txDone(o_txDone6), .o_rxData(o_rxData6),
        .o_sen(o_sen6), .o_sck(o_sck6), .o_sdat(o_sdat6), .i_sdi(1'b1)
    );

    typedef struct {
        logic [15:0] frame;
        int          beginCyc;
        logic [7:0]  rx;
        bit          gapCheck;
    } exp_t;

    typedef struct {
        logic [31:0] frame;
        int          beginCyc;
    } exp6_t;

    exp_t  q[$];
    exp6_t q6[$];

    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    bit   monOn = 1'b0;
    logic [7:0] rxModel = '0;
    logic [7:0] slaveData = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic slaveBit(input int idx);
        if (idx >= 8 && idx <= 15)
            return slaveData[15-idx];
        return 1'b0;
    endfunction

    // slave: shifts its next bit out after every SCK falling edge
    int   sFall = 0;
    logic sPrev = 1'b0;
    always @(negedge clk) begin
        if (o_sen !== 1'b0)
            sFall = 0;
        else if (o_sck == 1'b0 && sPrev == 1'b1)
            sFall++;
        sPrev = o_sck;
        sdi = slaveBit(sFall);
    end

    // monitor for the default instance
    logic [15:0] cap = '0;
    int   nb = 0, lowRun = 0, highRun = 0;
    logic prevSen = 1'b1, prevSck = 1'b0;
    bit   busyChk = 1'b0;
    always @(negedge clk) begin
        if (monOn && !rst) begin
            if (o_sen) begin
                highRun++;
            end else begin
                if (prevSen) begin
                    if (q.size() > 0 && q[0].gapCheck)
                        chk("cs_gap_cycles", highRun, 2);
                    highRun = 0;
                    cap = '0;
                    nb = 0;
                    lowRun = 0;
                end
                lowRun++;
                if (o_sck && !prevSck) begin
                    cap = {cap[14:0], o_sdat};
                    nb++;
                end
            end
            if (o_txDone) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("frame_bits", cap, e.frame);
                    chk("sck_rises", nb, 16);
                    chk("done_cycle", cyc, e.beginCyc + 35);
                    chk("sen_low_cycles", lowRun, 34);
                    chk("rx_data", o_rxData, e.rx);
                    chk("busy_at_done", o_txBusy, 1);
                end
                busyChk = 1'b1;
            end else if (busyChk) begin
                chk("busy_after_gap", o_txBusy, 0);
                busyChk = 1'b0;
            end
        end else begin
            busyChk = 1'b0;
            highRun = 0;
        end
        prevSen = o_sen;
        prevSck = o_sck;
    end

    // monitor for the wide/slow instance
    logic [31:0] cap6 = '0;
    int   nb6 = 0, firstRise6 = 0, period6 = 0, doneAt6 = -1;
    logic prevSen6 = 1'b1, prevSck6 = 1'b0;
    always @(negedge clk) begin
        if (monOn && !rst) begin
            if (!o_sen6 && prevSen6) begin
                cap6 = '0;
                nb6 = 0;
                period6 = 0;
            end
            if (!o_sen6 && o_sck6 && !prevSck6) begin
                cap6 = {cap6[30:0], o_sdat6};
                if (nb6 == 0)
                    firstRise6 = cyc;
                else if (nb6 == 1)
                    period6 = cyc - firstRise6;
                nb6++;
            end
            if (o_txDone6) begin
                if (q6.size() == 0) begin
                    chk("unexpected_done6", 1, 0);
                end else begin
                    exp6_t e;
                    e = q6.pop_front();
                    chk("frame_bits6", cap6, e.frame);
                    chk("sck_rises6", nb6, 32);
                    chk("sck_period6", period6, 8);
                    chk("done_cycle6", cyc, e.beginCyc + 259);
                    chk("rx_data6", o_rxData6, 0);
                end
                doneAt6 = cyc;
            end
            if (doneAt6 >= 0 && cyc == doneAt6 + 2)
                chk("busy6_in_gap", o_txBusy6, 1);
            if (doneAt6 >= 0 && cyc == doneAt6 + 3) begin
                chk("busy6_after_gap", o_txBusy6, 0);
                doneAt6 = -1;
            end
        end
        prevSen6 = o_sen6;
        prevSck6 = o_sck6;
    end

    task automatic startFrame(input bit rd, input logic [6:0] a,
                              input logic [7:0] d, input bit gap,
                              input bit push);
        exp_t e;
        @(negedge clk);
        txRead = rd;
        txAddr = a;
        txData = d;
        txBegin = 1'b1;
        if (push) begin
            if (rd)
                rxModel = slaveData;
            e.frame = {rd, a, rd ? 8'h00 : d};
            e.beginCyc = cyc;
            e.rx = rxModel;
            e.gapCheck = gap;
            q.push_back(e);
        end
        @(negedge clk);
        txBegin = 1'b0;
        txRead = ~rd;
        txAddr = ~a;
        txData = ~d;
    endtask

    task automatic waitDone(input bit six, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            @(negedge clk);
            got = six ? o_txDone6 : o_txDone;
        end
        if (!got) begin
            nChecks++;
            nFails++;
            $display("FAIL %s: done not seen, expected within 600 cycles", name);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        txBegin = 1'b1;
        txBegin6 = 1'b1;
        @(negedge clk);
        chk("rst_sen", o_sen, 1);
        chk("rst_sck", o_sck, 0);
        chk("rst_sdat", o_sdat, 0);
        chk("rst_busy", o_txBusy, 0);
        chk("rst_done", o_txDone, 0);
        chk("rst_rx", o_rxData, 0);
        chk("rst_sen6", o_sen6, 1);
        rst = 1'b0;
        txBegin = 1'b0;
        txBegin6 = 1'b0;
        @(negedge clk);
        chk("begin_in_reset_busy", o_txBusy, 0);
        chk("begin_in_reset_sen", o_sen, 1);
        monOn = 1'b1;
        idle(2);

        // 1: plain write
        startFrame(1'b0, 7'h12, 8'hA5, 1'b0, 1'b1);
        waitDone(1'b0, "t1");
        idle(4);

        // 2: read with slave returning 0x3C
        slaveData = 8'h3C;
        startFrame(1'b1, 7'h05, 8'hFF, 1'b0, 1'b1);
        waitDone(1'b0, "t2");
        idle(4);

        // 3: back-to-back sequencer writes
        for (int i = 0; i <= 20; i++) begin
            startFrame(1'b0, 7'h12, 8'(i), i > 0, 1'b1);
            waitDone(1'b0, "t3");
        end
        idle(6);

        // 4: begin pulses while busy are ignored
        startFrame(1'b0, 7'h3A, 8'h5C, 1'b0, 1'b1);
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            txBegin = 1'b1;
            txRead = 1'($urandom_range(0, 1));
            txAddr = 7'($urandom);
            txData = 8'($urandom);
        end
        @(negedge clk);
        txBegin = 1'b0;
        waitDone(1'b0, "t4");
        idle(40);

        // 5: reset during bit 5 of a write
        startFrame(1'b0, 7'h55, 8'hC3, 1'b0, 1'b0);
        idle(11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxModel = '0;
        chk("midrst_sen", o_sen, 1);
        chk("midrst_sck", o_sck, 0);
        chk("midrst_sdat", o_sdat, 0);
        chk("midrst_busy", o_txBusy, 0);
        chk("midrst_done", o_txDone, 0);
        chk("midrst_rx", o_rxData, 0);
        idle(40);
        startFrame(1'b0, 7'h6B, 8'h96, 1'b0, 1'b1);
        waitDone(1'b0, "t5");
        idle(4);

        // 6: wide frame on the slow instance
        begin
            exp6_t e;
            @(negedge clk);
            txAddr6 = 15'h1234;
            txData6 = 16'hBEEF;
            txBegin6 = 1'b1;
            e.frame = {1'b0, 15'h1234, 16'hBEEF};
            e.beginCyc = cyc;
            q6.push_back(e);
            @(negedge clk);
            txBegin6 = 1'b0;
            txAddr6 = '0;
            txData6 = '0;
        end
        waitDone(1'b1, "t6");
        idle(6);

        chk("queue_empty", q.size(), 0);
        chk("queue6_empty", q6.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
        $fatal(1, "watchdog");
    end

endmodule
